// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester-side command/response bundle for ram_port_arbiter
//
// One instance per requester.
//   address, byteenable, read, write, writedata : requester -> arbiter command
//   waitrequest                                 : arbiter -> requester, 1 = not accepted
//   readdata, readdatavalid                     : arbiter -> requester read response
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester arbiter in front of a single-port synchronous RAM
//
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   a, b                : requester bundles (ram_port_arbiter_if.slave)
//   ram_address         : RAM word address (holds last value when idle)
//   ram_byteenable      : RAM write byte lanes (holds last value when idle)
//   ram_writedata       : RAM write data (holds last value when idle)
//   ram_chipselect      : 1 on any granted cycle
//   ram_write           : 1 on a granted write
//   ram_clken           : RAM clock enable, high whenever out of reset
//   ram_readdata        : RAM q, valid one clock after the address edge
module ram_port_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  ram_port_arbiter_if.slave   a,
  ram_port_arbiter_if.slave   b,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  owner_t            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_a, req_b;
  logic              grant_a, grant_b;
  logic              owner_keeps;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wd_q;
  logic              rdv_a_q, rdv_b_q;

  assign req_a = a.read | a.write;
  assign req_b = b.read | b.write;

  // Owner keeps the port on a tie only inside an unfinished burst; a zero
  // count (idle last cycle, or just out of reset) hands a tie to the other side.
  assign owner_keeps = (cnt_q != '0) && (cnt_q < MAX_CNT);

  // Grants are gated by reset_n so that both waitrequests read high while
  // reset is held, even if requesters are already asserting commands.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset_n) begin
      if (req_a && req_b) begin
        if (owner_keeps) begin
          grant_a = (owner_q == OWNER_A);
          grant_b = (owner_q == OWNER_B);
        end else begin
          grant_a = (owner_q == OWNER_B);
          grant_b = (owner_q == OWNER_A);
        end
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (grant_a || grant_b) begin
      if ((grant_a && owner_q == OWNER_A) || (grant_b && owner_q == OWNER_B)) begin
        if (cnt_q < MAX_CNT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        owner_d = grant_a ? OWNER_A : OWNER_B;
        cnt_d   = CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // RAM command mux; the *_q registers replay the last driven values on idle cycles.
  always_comb begin
    ram_address    = addr_q;
    ram_byteenable = be_q;
    ram_writedata  = wd_q;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    if (grant_a) begin
      ram_address    = a.address;
      ram_byteenable = a.byteenable;
      ram_writedata  = a.writedata;
      ram_chipselect = 1'b1;
      ram_write      = a.write;
    end else if (grant_b) begin
      ram_address    = b.address;
      ram_byteenable = b.byteenable;
      ram_writedata  = b.writedata;
      ram_chipselect = 1'b1;
      ram_write      = b.write;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= OWNER_B;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rdv_a_q <= 1'b0;
      rdv_b_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= ram_address;
      be_q    <= ram_byteenable;
      wd_q    <= ram_writedata;
      // read+write together executes as a write, so it earns no response
      rdv_a_q <= grant_a & ~a.write;
      rdv_b_q <= grant_b & ~b.write;
    end
  end

  assign a.waitrequest   = ~grant_a;
  assign b.waitrequest   = ~grant_b;
  assign a.readdata      = ram_readdata;
  assign b.readdata      = ram_readdata;
  assign a.readdatavalid = rdv_a_q;
  assign b.readdatavalid = rdv_b_q;

  // Combinational from reset_n so the RAM is already enabled on the first
  // edge after release, when a grant can already be in flight.
  assign ram_clken = reset_n;

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the word-address width for the 2048-word RAM.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; byteenable width SHALL be DATA_W/8.
REQ-003 Parameter MAX_BURST, default 4, range 1..15, SHALL set the maximum consecutive grants to one requester while the other waits.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 a_address / b_address  in  ADDR_W  requester word address.
REQ-007 a_byteenable / b_byteenable  in  DATA_W/8  write byte lanes.
REQ-008 a_read / b_read  in  1  read request.
REQ-009 a_write / b_write  in  1  write request.
REQ-010 a_writedata / b_writedata  in  DATA_W  write data.
REQ-011 a_waitrequest / b_waitrequest  out  1  high = command not accepted this cycle.
REQ-012 a_readdata / b_readdata  out  DATA_W  read data.
REQ-013 a_readdatavalid / b_readdatavalid  out  1  read data valid strobe.
REQ-014 ram_address  out  ADDR_W  to RAM port.
REQ-015 ram_byteenable  out  DATA_W/8  to RAM port.
REQ-016 ram_chipselect, ram_write  out  1 each  to RAM port.
REQ-017 ram_writedata  out  DATA_W  to RAM port.
REQ-018 ram_clken  out  1  RAM clock enable, constant high outside reset.
REQ-019 ram_readdata  in  DATA_W  RAM q output, valid one clk after the address edge.

Function
REQ-020 Requester X SHALL be requesting when x_read | x_write; if both are high, the command SHALL be treated as a write.
REQ-021 State: owner (A/B) and burst_cnt (0..MAX_BURST).
REQ-022 Only one requester requesting: that requester SHALL be granted.
REQ-023 Both requesting: owner SHALL be granted iff 0 < burst_cnt < MAX_BURST; otherwise the non-owner SHALL be granted.
REQ-024 Grant SHALL be decided combinationally in the same cycle; the grantee's waitrequest SHALL be low and all other waitrequests high, including for idle requesters.
REQ-025 On a grant, the RAM outputs SHALL carry the grantee's address, byteenable and writedata; ram_chipselect SHALL be 1 and ram_write SHALL equal the grantee's write.
REQ-026 With no grant: ram_chipselect = 0, ram_write = 0, and the other RAM outputs SHALL hold their last values.
REQ-027 Edge update on a grant to the same owner: burst_cnt += 1, saturating at MAX_BURST.
REQ-028 Edge update on a grant to the non-owner: owner := grantee and burst_cnt := 1.
REQ-029 Edge update with no grant: burst_cnt := 0 and owner unchanged.
REQ-030 A granted read SHALL assert the grantee's readdatavalid for exactly the following cycle; other readdatavalid outputs SHALL stay low.
REQ-031 a_readdata and b_readdata SHALL both equal ram_readdata; they are meaningful only when the matching readdatavalid is high.
REQ-032 Back-to-back reads SHALL sustain one read per cycle, with one readdatavalid per accepted read, in order.
REQ-033 Writes SHALL complete in the grant cycle with no response strobe.
REQ-034 A write followed by a read to the same address on the next grant SHALL return the new data.

Reset
REQ-035 While reset_n = 0: owner = B, burst_cnt = 0, all readdatavalid = 0, ram_chipselect = 0, ram_write = 0, ram_clken = 0, ram_address = 0, and both waitrequests = 1.
REQ-036 Assertion of reset_n mid-transaction SHALL drop any pending readdatavalid.
REQ-037 The first grant after release SHALL obey REQ-022/REQ-023; on a tie after reset, A wins.

Verification
REQ-038 Reset tie: release reset, assert a_read@0x010 and b_read@0x020 together -> A granted in cycle 0; a_readdatavalid=1 in cycle 1 with RAM[0x010].
REQ-039 Burst fairness, MAX_BURST=4: A and B both hold continuous writes -> grant pattern A,A,A,A,B,B,B,B,A…; no requester waits more than 4 cycles.
REQ-040 Sole requester: B streams reads 0x000..0x007 with A idle -> 8 consecutive grants, b_readdatavalid high for 8 consecutive cycles, data in order.
REQ-041 Write-then-read: A writes 0xDEADBEEF to 0x7FF with byteenable=0x3, then reads 0x7FF -> low half 0xBEEF, upper half unchanged.
REQ-042 Read+write both high on A -> executed as a write; no a_readdatavalid.
REQ-043 reset_n pulsed low in the cycle after a granted read -> no readdatavalid; all outputs at their reset values.
